// File: rtl/ivsi_pkg.sv
// Shared types and defaults for the vSwitch ingress dispatcher.
// Holds the FSM state encoding, the default stream widths and the drop counter ceiling.
package ivsi_pkg;

  localparam int DEF_DATA_W  = 256;
  localparam int DEF_TUSER_W = 128;
  localparam int DEF_NUM_VS  = 4;
  localparam int DEF_SEL_LSB = 32;
  localparam int DEF_SEL_W   = 2;

  localparam logic [31:0] DROP_CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Width of a lane index; never zero so a single-lane build still has a select bit.
  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ivsi_out_reg.sv
// Single shared output holding register for all vSwitch lanes.
// Data fields are broadcast; only the lane selected by sel_p1 sees tvalid.
module ivsi_out_reg
  import ivsi_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TUSER_W = DEF_TUSER_W,
  parameter int NUM_VS  = DEF_NUM_VS,
  parameter int LANE_W  = lane_w(NUM_VS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [LANE_W-1:0]         in_sel,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [DATA_W/8-1:0]       in_keep,
  input  logic [TUSER_W-1:0]        in_user,
  input  logic                      in_last,
  input  logic [NUM_VS-1:0]         m_axis_tready,
  output logic                      can_accept,
  output logic [NUM_VS*DATA_W-1:0]  m_axis_tdata,
  output logic [NUM_VS*DATA_W/8-1:0] m_axis_tkeep,
  output logic [NUM_VS*TUSER_W-1:0] m_axis_tuser,
  output logic [NUM_VS-1:0]         m_axis_tvalid,
  output logic [NUM_VS-1:0]         m_axis_tlast
);

  logic                vld_p1;
  logic [LANE_W-1:0]   sel_p1;
  logic [DATA_W-1:0]   data_p1;
  logic [DATA_W/8-1:0] keep_p1;
  logic [TUSER_W-1:0]  user_p1;
  logic                last_p1;
  logic                lane_rdy;

  assign lane_rdy   = m_axis_tready[sel_p1];
  assign can_accept = !vld_p1 || lane_rdy;

  // Stage p1: contents only change on a load, so they stay put while the lane stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      sel_p1  <= '0;
      data_p1 <= '0;
      keep_p1 <= '0;
      user_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      sel_p1  <= in_sel;
      data_p1 <= in_data;
      keep_p1 <= in_keep;
      user_p1 <= in_user;
      last_p1 <= in_last;
    end else if (vld_p1 && lane_rdy) begin
      vld_p1 <= 1'b0;
    end
  end

  always_comb begin
    m_axis_tvalid = '0;
    for (int i = 0; i < NUM_VS; i++)
      m_axis_tvalid[i] = vld_p1 && (sel_p1 == LANE_W'(i));
  end

  assign m_axis_tdata = {NUM_VS{data_p1}};
  assign m_axis_tkeep = {NUM_VS{keep_p1}};
  assign m_axis_tuser = {NUM_VS{user_p1}};
  assign m_axis_tlast = {NUM_VS{last_p1}};

endmodule

// File: rtl/ivsi_dispatch.sv
// Routes ingress packets to one of NUM_VS vSwitch lanes by a tuser field,
// dropping whole packets aimed at absent or disabled partitions.
module ivsi_dispatch
  import ivsi_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = DEF_DATA_W,
  parameter int C_AXIS_TUSER_WIDTH = DEF_TUSER_W,
  parameter int NUM_VS             = DEF_NUM_VS,
  parameter int SEL_LSB            = DEF_SEL_LSB,
  parameter int SEL_WIDTH          = DEF_SEL_W
) (
  input  logic                                   axis_aclk,
  input  logic                                   axis_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]         s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]          s_axis_tuser,
  input  logic                                   s_axis_tvalid,
  input  logic                                   s_axis_tlast,
  output logic                                   s_axis_tready,
  output logic [NUM_VS*C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [NUM_VS*C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [NUM_VS*C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [NUM_VS-1:0]                      m_axis_tvalid,
  output logic [NUM_VS-1:0]                      m_axis_tlast,
  input  logic [NUM_VS-1:0]                      m_axis_tready,
  input  logic [NUM_VS-1:0]                      vs_enable,
  output logic [31:0]                            drop_count
);

  localparam int LANE_W = lane_w(NUM_VS);

  state_t               state, state_nxt;
  logic [LANE_W-1:0]    lane_q, lane_nxt, cur_lane, sel_lane;
  logic [SEL_WIDTH-1:0] sel;
  logic                 fwd_ok, can_accept, s_rdy, load, cnt_inc;

  assign sel      = s_axis_tuser[SEL_LSB +: SEL_WIDTH];
  assign sel_lane = LANE_W'(sel);

  // Out-of-range IDs match no lane and therefore fall through to a drop
  always_comb begin
    fwd_ok = 1'b0;
    for (int i = 0; i < NUM_VS; i++)
      if (32'(sel) == 32'(i)) fwd_ok = vs_enable[i];
  end

  always_comb begin
    state_nxt = state;
    lane_nxt  = lane_q;
    cur_lane  = lane_q;
    s_rdy     = 1'b0;
    load      = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        cur_lane = sel_lane;
        s_rdy    = fwd_ok ? can_accept : 1'b1;
        if (s_axis_tvalid && s_rdy) begin
          load     = fwd_ok;
          cnt_inc  = !fwd_ok;
          lane_nxt = sel_lane;
          if (!s_axis_tlast) state_nxt = fwd_ok ? ST_FWD : ST_DROP;
        end
      end
      ST_FWD: begin
        s_rdy = can_accept;
        if (s_axis_tvalid && s_rdy) begin
          load = 1'b1;
          if (s_axis_tlast) state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        s_rdy = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign s_axis_tready = axis_resetn && s_rdy;

  // Stage p0: packet-level decision, held until the tlast beat is taken
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state  <= ST_IDLE;
      lane_q <= '0;
    end else begin
      state  <= state_nxt;
      lane_q <= lane_nxt;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn)
      drop_count <= '0;
    else if (cnt_inc && (drop_count != DROP_CNT_MAX))
      drop_count <= drop_count + 32'd1;
  end

  ivsi_out_reg #(
    .DATA_W  (C_AXIS_DATA_WIDTH),
    .TUSER_W (C_AXIS_TUSER_WIDTH),
    .NUM_VS  (NUM_VS),
    .LANE_W  (LANE_W)
  ) u_out_reg (
    .clk           (axis_aclk),
    .rst_n         (axis_resetn),
    .load          (load),
    .in_sel        (cur_lane),
    .in_data       (s_axis_tdata),
    .in_keep       (s_axis_tkeep),
    .in_user       (s_axis_tuser),
    .in_last       (s_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .can_accept    (can_accept),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast)
  );

endmodule

// File: tb/tb_ivsi_dispatch.sv
// Directed bench for ivsi_dispatch: routing, drops, mid-packet enable change,
// backpressure, single-beat streams and reset in the middle of a packet.
module tb_ivsi_dispatch;
  import ivsi_pkg::*;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int NV = 4;
  localparam int KW = DW / 8;

  logic              axis_aclk = 1'b0;
  logic              axis_resetn = 1'b0;
  logic [DW-1:0]     s_axis_tdata = '0;
  logic [KW-1:0]     s_axis_tkeep = '0;
  logic [UW-1:0]     s_axis_tuser = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tready;
  logic [NV*DW-1:0]  m_axis_tdata;
  logic [NV*KW-1:0]  m_axis_tkeep;
  logic [NV*UW-1:0]  m_axis_tuser;
  logic [NV-1:0]     m_axis_tvalid;
  logic [NV-1:0]     m_axis_tlast;
  logic [NV-1:0]     m_axis_tready = '1;
  logic [NV-1:0]     vs_enable = '1;
  logic [31:0]       drop_count;

  int vectors = 0;
  int miscompares = 0;

  ivsi_dispatch dut (
    .axis_aclk     (axis_aclk),
    .axis_resetn   (axis_resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .vs_enable     (vs_enable),
    .drop_count    (drop_count)
  );

  always #5 axis_aclk = ~axis_aclk;

  function automatic logic [DW-1:0] mk_data(input int tag, input int idx);
    logic [31:0] w;
    w = 32'hA500_0000 | 32'(tag * 256 + idx);
    return {(DW/32){w}};
  endfunction

  function automatic logic [KW-1:0] mk_keep(input bit last);
    return last ? {{(KW/2){1'b0}}, {(KW/2){1'b1}}} : {KW{1'b1}};
  endfunction

  function automatic logic [UW-1:0] mk_user(input int tag, input int sel);
    logic [UW-1:0] u;
    u = '0;
    u[31:0]      = 32'(tag);
    u[33:32]     = 2'(sel);
    u[UW-1 -: 32] = 32'hC0DE_0000 | 32'(tag);
    return u;
  endfunction

  task automatic drive_beat(input int tag, input int idx, input int sel, input bit last);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = mk_data(tag, idx);
    s_axis_tkeep  = mk_keep(last);
    s_axis_tuser  = mk_user(tag, sel);
    s_axis_tlast  = last;
  endtask

  task automatic drive_idle();
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic test_reset();
    axis_resetn = 1'b0;
    drive_idle();
    repeat (2) @(posedge axis_aclk);
    #3;
    vectors++;
    if (m_axis_tvalid !== '0) begin
      miscompares++;
      $display("FAIL rst_tvalid got %b want 0000", m_axis_tvalid);
    end
    vectors++;
    if (s_axis_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_tready got %b want 0", s_axis_tready);
    end
    vectors++;
    if (drop_count !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_drop_count got %0d want 0", drop_count);
    end
    vectors++;
    if (m_axis_tdata !== '0 || m_axis_tlast !== '0 || m_axis_tuser !== '0 || m_axis_tkeep !== '0) begin
      miscompares++;
      $display("FAIL rst_regs got data %h last %b want zero", m_axis_tdata[DW-1:0], m_axis_tlast);
    end
    axis_resetn = 1'b1;
    #1;
    vectors++;
    if (s_axis_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_release_tready got %b want 1", s_axis_tready);
    end
    next_cycle();
  endtask

  // 3-beat packet to lane 2, every lane ready
  task automatic test_forward();
    logic [NV-1:0] exp_v, exp_l;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive_beat(1, c, 2, c == 2);
      else drive_idle();
      #4;
      if (c < 3) begin
        vectors++;
        if (s_axis_tready !== 1'b1) begin
          miscompares++;
          $display("FAIL fwd_tready c=%0d got %b want 1", c, s_axis_tready);
        end
      end
      exp_v = (c >= 1 && c <= 3) ? 4'b0100 : 4'b0000;
      vectors++;
      if (m_axis_tvalid !== exp_v) begin
        miscompares++;
        $display("FAIL fwd_tvalid c=%0d got %b want %b", c, m_axis_tvalid, exp_v);
      end
      if (c >= 1 && c <= 3) begin
        exp_l = (c == 3) ? 4'b1111 : 4'b0000;
        vectors++;
        if (m_axis_tdata !== {NV{mk_data(1, c - 1)}} || m_axis_tlast !== exp_l) begin
          miscompares++;
          $display("FAIL fwd_data c=%0d got %h last %b want %h last %b", c,
                   m_axis_tdata[DW-1:0], m_axis_tlast, mk_data(1, c - 1), exp_l);
        end
        vectors++;
        if (m_axis_tuser !== {NV{mk_user(1, 2)}} || m_axis_tkeep !== {NV{mk_keep(c == 3)}}) begin
          miscompares++;
          $display("FAIL fwd_user_keep c=%0d got %h %h want %h %h", c, m_axis_tuser[UW-1:0],
                   m_axis_tkeep[KW-1:0], mk_user(1, 2), mk_keep(c == 3));
        end
      end
      if (c == 4) begin
        vectors++;
        if (drop_count !== 32'd0) begin
          miscompares++;
          $display("FAIL fwd_drop_count got %0d want 0", drop_count);
        end
      end
      next_cycle();
    end
  endtask

  // Same packet with lane 2 disabled: swallowed and counted once
  task automatic test_drop();
    vs_enable = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive_beat(2, c, 2, c == 2);
      else drive_idle();
      #4;
      if (c < 3) begin
        vectors++;
        if (s_axis_tready !== 1'b1) begin
          miscompares++;
          $display("FAIL drop_tready c=%0d got %b want 1", c, s_axis_tready);
        end
      end
      vectors++;
      if (m_axis_tvalid !== 4'b0000) begin
        miscompares++;
        $display("FAIL drop_tvalid c=%0d got %b want 0000", c, m_axis_tvalid);
      end
      if (c == 1 || c == 4) begin
        vectors++;
        if (drop_count !== 32'd1) begin
          miscompares++;
          $display("FAIL drop_count c=%0d got %0d want 1", c, drop_count);
        end
      end
      next_cycle();
    end
    vs_enable = 4'b1111;
  endtask

  // Lane 1 disabled during beat 2: this packet completes, the next is dropped
  task automatic test_midpkt_disable();
    logic [NV-1:0] exp_v, exp_l;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive_beat(3, c, 1, c == 3);
      else drive_idle();
      if (c == 1) vs_enable = 4'b1101;
      #4;
      if (c < 4) begin
        vectors++;
        if (s_axis_tready !== 1'b1) begin
          miscompares++;
          $display("FAIL mid_tready c=%0d got %b want 1", c, s_axis_tready);
        end
      end
      exp_v = (c >= 1 && c <= 4) ? 4'b0010 : 4'b0000;
      vectors++;
      if (m_axis_tvalid !== exp_v) begin
        miscompares++;
        $display("FAIL mid_tvalid c=%0d got %b want %b", c, m_axis_tvalid, exp_v);
      end
      if (c >= 1 && c <= 4) begin
        exp_l = (c == 4) ? 4'b1111 : 4'b0000;
        vectors++;
        if (m_axis_tdata !== {NV{mk_data(3, c - 1)}} || m_axis_tlast !== exp_l) begin
          miscompares++;
          $display("FAIL mid_data c=%0d got %h last %b want %h last %b", c,
                   m_axis_tdata[DW-1:0], m_axis_tlast, mk_data(3, c - 1), exp_l);
        end
      end
      next_cycle();
    end
    for (int c = 0; c < 4; c++) begin
      if (c < 2) drive_beat(4, c, 1, c == 1);
      else drive_idle();
      #4;
      if (c < 2) begin
        vectors++;
        if (s_axis_tready !== 1'b1) begin
          miscompares++;
          $display("FAIL mid2_tready c=%0d got %b want 1", c, s_axis_tready);
        end
      end
      vectors++;
      if (m_axis_tvalid !== 4'b0000) begin
        miscompares++;
        $display("FAIL mid2_tvalid c=%0d got %b want 0000", c, m_axis_tvalid);
      end
      next_cycle();
    end
    vectors++;
    if (drop_count !== 32'd2) begin
      miscompares++;
      $display("FAIL mid2_drop_count got %0d want 2", drop_count);
    end
    vs_enable = 4'b1111;
  endtask

  // Lane 0 ready low for 5 cycles after the first beat is registered
  task automatic test_backpressure();
    int b, o;
    logic exp_r;
    logic [NV-1:0] exp_l;
    for (int c = 0; c < 11; c++) begin
      b = (c == 0) ? 0 : (c <= 6) ? 1 : (c == 7) ? 2 : 3;
      if (c <= 8) drive_beat(5, b, 0, b == 3);
      else drive_idle();
      m_axis_tready = (c >= 1 && c <= 5) ? 4'b1110 : 4'b1111;
      #4;
      if (c <= 8) begin
        exp_r = (c >= 1 && c <= 5) ? 1'b0 : 1'b1;
        vectors++;
        if (s_axis_tready !== exp_r) begin
          miscompares++;
          $display("FAIL bp_tready c=%0d got %b want %b", c, s_axis_tready, exp_r);
        end
      end
      o = (c >= 1 && c <= 6) ? 0 : (c == 7) ? 1 : (c == 8) ? 2 : (c == 9) ? 3 : -1;
      vectors++;
      if (m_axis_tvalid !== ((o >= 0) ? 4'b0001 : 4'b0000)) begin
        miscompares++;
        $display("FAIL bp_tvalid c=%0d got %b want %b", c, m_axis_tvalid,
                 (o >= 0) ? 4'b0001 : 4'b0000);
      end
      if (o >= 0) begin
        exp_l = (o == 3) ? 4'b1111 : 4'b0000;
        vectors++;
        if (m_axis_tdata !== {NV{mk_data(5, o)}} || m_axis_tlast !== exp_l) begin
          miscompares++;
          $display("FAIL bp_data c=%0d got %h last %b want %h last %b", c,
                   m_axis_tdata[DW-1:0], m_axis_tlast, mk_data(5, o), exp_l);
        end
      end
      next_cycle();
    end
    m_axis_tready = 4'b1111;
  endtask

  // Single-beat packets alternating lanes 0 and 3, one per cycle
  task automatic test_back_to_back();
    logic [NV-1:0] exp_v;
    for (int c = 0; c < 8; c++) begin
      if (c < 6) drive_beat(10 + c, 0, (c % 2 == 1) ? 3 : 0, 1'b1);
      else drive_idle();
      #4;
      if (c < 6) begin
        vectors++;
        if (s_axis_tready !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_tready c=%0d got %b want 1", c, s_axis_tready);
        end
      end
      exp_v = (c >= 1 && c <= 6) ? (((c - 1) % 2 == 1) ? 4'b1000 : 4'b0001) : 4'b0000;
      vectors++;
      if (m_axis_tvalid !== exp_v) begin
        miscompares++;
        $display("FAIL b2b_tvalid c=%0d got %b want %b", c, m_axis_tvalid, exp_v);
      end
      if (c >= 1 && c <= 6) begin
        vectors++;
        if (m_axis_tdata !== {NV{mk_data(10 + c - 1, 0)}} || m_axis_tlast !== 4'b1111) begin
          miscompares++;
          $display("FAIL b2b_data c=%0d got %h last %b want %h last 1111", c,
                   m_axis_tdata[DW-1:0], m_axis_tlast, mk_data(10 + c - 1, 0));
        end
        vectors++;
        if (dut.state !== ST_IDLE) begin
          miscompares++;
          $display("FAIL b2b_state c=%0d got %0d want %0d", c, dut.state, ST_IDLE);
        end
      end
      next_cycle();
    end
    vectors++;
    if (drop_count !== 32'd2) begin
      miscompares++;
      $display("FAIL b2b_drop_count got %0d want 2", drop_count);
    end
  endtask

  // Reset asserted during beat 2 of a lane-3 packet, then a clean lane-1 packet
  task automatic test_reset_midpkt();
    logic [NV-1:0] exp_v, exp_l;
    drive_beat(20, 0, 3, 1'b0);
    next_cycle();
    drive_beat(20, 1, 3, 1'b0);
    #4;
    vectors++;
    if (m_axis_tvalid !== 4'b1000) begin
      miscompares++;
      $display("FAIL rmid_pre_tvalid got %b want 1000", m_axis_tvalid);
    end
    axis_resetn = 1'b0;
    #1;
    vectors++;
    if (m_axis_tvalid !== 4'b0000 || s_axis_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_async got tvalid %b tready %b want 0000 0", m_axis_tvalid, s_axis_tready);
    end
    vectors++;
    if (m_axis_tdata !== '0 || m_axis_tlast !== '0 || drop_count !== 32'd0) begin
      miscompares++;
      $display("FAIL rmid_clear got data %h last %b drops %0d want 0", m_axis_tdata[DW-1:0],
               m_axis_tlast, drop_count);
    end
    next_cycle();
    drive_idle();
    next_cycle();
    axis_resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c < 2) drive_beat(21, c, 1, c == 1);
      else drive_idle();
      #4;
      if (c < 2) begin
        vectors++;
        if (s_axis_tready !== 1'b1) begin
          miscompares++;
          $display("FAIL rmid_tready c=%0d got %b want 1", c, s_axis_tready);
        end
      end
      exp_v = (c >= 1 && c <= 2) ? 4'b0010 : 4'b0000;
      vectors++;
      if (m_axis_tvalid !== exp_v) begin
        miscompares++;
        $display("FAIL rmid_tvalid c=%0d got %b want %b", c, m_axis_tvalid, exp_v);
      end
      if (c >= 1 && c <= 2) begin
        exp_l = (c == 2) ? 4'b1111 : 4'b0000;
        vectors++;
        if (m_axis_tdata !== {NV{mk_data(21, c - 1)}} || m_axis_tlast !== exp_l) begin
          miscompares++;
          $display("FAIL rmid_data c=%0d got %h last %b want %h last %b", c,
                   m_axis_tdata[DW-1:0], m_axis_tlast, mk_data(21, c - 1), exp_l);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_drop();
    test_midpkt_disable();
    test_backpressure();
    test_back_to_back();
    test_reset_midpkt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
